// File: rtl/apb_mst_bridge_if.sv
// Native request/acknowledge port plus APB initiator signals for apb_mst_bridge.
// The master modport is the bridge side; the slave modport is the requester/responder side.
interface apb_mst_bridge_if #(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  req_vld;
  logic                  wr_en;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  ack_vld;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  err;
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic                  PREADY;
  logic                  PSLVERR;
  logic [DATA_WIDTH-1:0] PRDATA;

  modport master (
    input  req_vld, wr_en, rd_en, addr, wr_data, PREADY, PSLVERR, PRDATA,
    output ack_vld, rd_data, err, PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

  modport slave (
    output req_vld, wr_en, rd_en, addr, wr_data, PREADY, PSLVERR, PRDATA,
    input  ack_vld, rd_data, err, PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );
endinterface

// File: rtl/apb_mst_bridge.sv
// Native single-request port to APB initiator bridge with wait-state timeout.
// Every output is a flop; a three-state FSM sequences SETUP and ACCESS phases.
module apb_mst_bridge #(
  parameter int unsigned ADDR_WIDTH     = 64,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                 fsm_clk,
  input  logic                 fsm_rst,
  apb_mst_bridge_if.master     bus
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d, cnt_inc;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                  ack_q, ack_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  assign cnt_inc = cnt_q + CntW'(1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    rdata_d   = '0;
    unique case (state_q)
      StIdle: begin
        if (bus.req_vld) begin
          if (bus.wr_en ^ bus.rd_en) begin
            state_d   = StSetup;
            cnt_d     = '0;
            psel_d    = 1'b1;
            penable_d = 1'b0;
            pwrite_d  = bus.wr_en;
            paddr_d   = bus.addr;
            pwdata_d  = bus.wr_en ? bus.wr_data : '0;
          end else begin
            // Malformed request: answer with an error, never touch the APB bus.
            ack_d = 1'b1;
            err_d = 1'b1;
          end
        end
      end
      StSetup: begin
        state_d   = StAccess;
        penable_d = 1'b1;
      end
      StAccess: begin
        if (bus.PREADY) begin
          state_d   = StIdle;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          ack_d     = 1'b1;
          err_d     = bus.PSLVERR;
          rdata_d   = (!pwrite_q && !bus.PSLVERR) ? bus.PRDATA : '0;
        end else begin
          cnt_d = cnt_inc;
          // Abort on the TIMEOUT_CYCLES-th stalled ACCESS cycle; counter cannot wrap.
          if (cnt_inc == CntW'(TIMEOUT_CYCLES)) begin
            state_d   = StIdle;
            psel_d    = 1'b0;
            penable_d = 1'b0;
            ack_d     = 1'b1;
            err_d     = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge fsm_clk or posedge fsm_rst) begin
    if (fsm_rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
    end
  end

  assign bus.PSEL    = psel_q;
  assign bus.PENABLE = penable_q;
  assign bus.PWRITE  = pwrite_q;
  assign bus.PADDR   = paddr_q;
  assign bus.PWDATA  = pwdata_q;
  assign bus.ack_vld = ack_q;
  assign bus.err     = err_q;
  assign bus.rd_data = rdata_q;

endmodule

// File: doc/apb_mst_bridge.md
APB_MST_BRIDGE -- requirements
Module: apb_mst_bridge

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 64, the address width of both ports.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, the data width of both ports.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, the maximum number of ACCESS cycles allowed before a transfer is aborted.
REQ-004 Ports SHALL be as follows (name, direction, width, meaning):
- fsm_clk in 1: single clock for all logic.
- fsm_rst in 1: asynchronous, active-high reset.
- req_vld in 1: native request strobe, one cycle wide.
- wr_en in 1: write request, qualified by req_vld.
- rd_en in 1: read request, qualified by req_vld.
- addr in ADDR_WIDTH: request address.
- wr_data in DATA_WIDTH: write data.
- ack_vld out 1: completion strobe, one cycle wide.
- rd_data out DATA_WIDTH: read data, valid while ack_vld=1.
- err out 1: transfer error (PSLVERR, timeout or illegal request), valid while ack_vld=1.
- PSEL, PENABLE, PWRITE out 1 each: APB initiator controls.
- PADDR out ADDR_WIDTH, PWDATA out DATA_WIDTH: APB address and write data.
- PREADY, PSLVERR in 1 each; PRDATA in DATA_WIDTH: APB responder returns.

Function
REQ-005 The block SHALL use a three-state FSM with states IDLE, SETUP and ACCESS; all outputs SHALL be registered.
REQ-006 IDLE→SETUP on req_vld=1 with exactly one of wr_en/rd_en set; the block SHALL latch addr, wr_data and wr_en into PADDR, PWDATA and PWRITE, and drive PSEL=1, PENABLE=0.
REQ-007 SETUP→ACCESS unconditionally after one cycle, with PENABLE=1; PADDR, PWDATA, PWRITE and PSEL SHALL be held stable.
REQ-008 In ACCESS with PREADY=1, the block SHALL go to IDLE, drop PSEL and PENABLE, and pulse ack_vld for the next cycle with err=PSLVERR; rd_data SHALL be PRDATA for a read, or 0 for a write or for any error.
REQ-009 In ACCESS with PREADY=0, the block SHALL stay in ACCESS and increment the wait counter.
REQ-010 Timeout: when the wait counter reaches TIMEOUT_CYCLES with PREADY still 0, the block SHALL abort, drop PSEL and PENABLE, return to IDLE, and pulse ack_vld with err=1 and rd_data=0.
REQ-011 The wait counter SHALL be $clog2(TIMEOUT_CYCLES+1) bits wide, SHALL clear on entering SETUP, and SHALL never wrap.
REQ-012 Minimum latency SHALL be: req_vld sampled at edge N → SETUP in cycle N+1 → ACCESS in N+2 → ack_vld=1 in N+3.
REQ-013 An illegal request (req_vld=1 with wr_en=rd_en=1, or with both 0) received in IDLE SHALL NOT start an APB transfer, and SHALL produce ack_vld=1, err=1, rd_data=0 in the next cycle.
REQ-014 A req_vld received while not in IDLE SHALL be ignored; the transfer in flight SHALL be unaffected, and the dropped request SHALL NOT be acknowledged.
REQ-015 A req_vld arriving in the same cycle that ack_vld=1 is driven (FSM already in IDLE) SHALL be accepted normally.
REQ-016 ack_vld SHALL never stay high for two consecutive cycles, except for back-to-back illegal requests.
REQ-017 PWDATA SHALL be driven as 0 on reads.

Reset
REQ-018 While fsm_rst=1, regardless of clock, the block SHALL force: FSM=IDLE, counter=0, PSEL=PENABLE=PWRITE=0, PADDR=0, PWDATA=0, ack_vld=0, err=0, rd_data=0.
REQ-019 Reset asserted mid-transfer SHALL abort the transfer immediately with no ack_vld; the first request after fsm_rst falls SHALL be serviced normally.

Verification
REQ-020 Write with zero wait states: req_vld, wr_en=1, addr=0x10, wr_data=0x12345678, with PREADY tied to 1 → PSEL=1 in N+1, PENABLE=1 in N+2, PWDATA=0x12345678, ack_vld=1 in N+3, err=0, rd_data=0.
REQ-021 Read with 3 wait states: rd_en=1, addr=0x14, responder holds PREADY=0 for 3 ACCESS cycles then returns PRDATA=0x87654321 → ack_vld=1 in N+6 with rd_data=0x87654321 and err=0.
REQ-022 Error and timeout: responder returns PSLVERR=1 with PREADY=1 → ack_vld with err=1, rd_data=0. Separately, with TIMEOUT_CYCLES=4 and PREADY stuck at 0 → ack_vld with err=1 after exactly 4 ACCESS cycles, and PSEL=0 afterwards.
REQ-023 Illegal and busy requests: req_vld with wr_en=rd_en=1 → no PSEL, ack_vld and err=1 in the next cycle. A second req_vld issued during ACCESS → ignored, and only one ack_vld is seen.
REQ-024 Reset mid-transfer: assert fsm_rst between clock edges during ACCESS → PSEL and PENABLE go to 0 immediately with no ack_vld; after release, a write to 0x10 completes with normal latency.
